// File: rtl/pulse_sched_arbiter_if.sv
// Bundle of the request/generator signals shared between the requesters,
// the shared pulse-at-N generator and pulse_sched_arbiter.
//
// Signals:
//   Req    [3:0]       request bits, one per requester
//   N0..N3 [WIDTH-1:0] terminal count per requester
//   K0..K3 [KW-1:0]    pulse count wanted per requester
//   Pulse              pulse returned by the shared generator
//   PN     [WIDTH-1:0] N value driven to the shared generator
//   Grant  [3:0]       one-hot owner, or zero
//   Tick   [3:0]       Pulse routed to the owner while running
//   Done   [3:0]       completion strobe to the owner
//   Err                strobe with Done when latched N or K was 0
//   Busy               arbiter not idle
//
// master: requester/generator side. slave: the arbiter.
interface pulse_sched_arbiter_if #(
    parameter int WIDTH = 10,
    parameter int KW    = 8
);
    logic [3:0]       Req;
    logic [WIDTH-1:0] N0, N1, N2, N3;
    logic [KW-1:0]    K0, K1, K2, K3;
    logic             Pulse;
    logic [WIDTH-1:0] PN;
    logic [3:0]       Grant;
    logic [3:0]       Tick;
    logic [3:0]       Done;
    logic             Err;
    logic             Busy;

    modport master (
        output Req, N0, N1, N2, N3, K0, K1, K2, K3, Pulse,
        input  PN, Grant, Tick, Done, Err, Busy
    );

    modport slave (
        input  Req, N0, N1, N2, N3, K0, K1, K2, K3, Pulse,
        output PN, Grant, Tick, Done, Err, Busy
    );
endinterface

// File: rtl/pulse_sched_arbiter.sv
// Round-robin scheduler sharing one programmable pulse-at-N generator among
// four requesters. The winner's N is driven on PN, returned pulses are routed
// to the winner as Tick and counted; ownership is released after K pulses,
// on an abandoned request, or immediately when the latched N or K is zero.
//
// Ports:
//   Clk    system clock
//   Reset  asynchronous, active-high reset
//   bus    pulse_sched_arbiter_if.slave (Req, N0..N3, K0..K3, Pulse in;
//          PN, Grant, Tick, Done, Err, Busy out)
//
// All outputs are registered except Tick, which is Pulse gated by RUN and
// the grant.
module pulse_sched_arbiter #(
    parameter int WIDTH = 10,
    parameter int KW    = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    pulse_sched_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

    state_t           state, state_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [WIDTH-1:0] n_lat, n_nxt;
    logic [KW-1:0]    k_lat, k_nxt;
    logic [KW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] pn_q, pn_nxt;
    logic [3:0]       grant_q, grant_nxt;
    logic [3:0]       done_q, done_nxt;
    logic             err_q, err_nxt;
    logic             busy_q, busy_nxt;

    logic [WIDTH-1:0] n_in [4];
    logic [KW-1:0]    k_in [4];

    logic             pick_vld;
    logic [1:0]       pick;

    assign n_in[0] = bus.N0;
    assign n_in[1] = bus.N1;
    assign n_in[2] = bus.N2;
    assign n_in[3] = bus.N3;
    assign k_in[0] = bus.K0;
    assign k_in[1] = bus.K1;
    assign k_in[2] = bus.K2;
    assign k_in[3] = bus.K3;

    // Round-robin search starting at ptr. Scanning offsets from high to low
    // lets the smallest offset with a set Req bit win.
    always_comb begin
        logic [1:0] j;
        pick_vld = 1'b0;
        pick     = ptr;
        j        = ptr;
        for (int i = 3; i >= 0; i--) begin
            j = ptr + 2'(i);
            if (bus.Req[j]) begin
                pick_vld = 1'b1;
                pick     = j;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = idx;
        n_nxt     = n_lat;
        k_nxt     = k_lat;
        cnt_nxt   = cnt;
        pn_nxt    = pn_q;
        grant_nxt = grant_q;
        done_nxt  = 4'b0000;
        err_nxt   = 1'b0;

        case (state)
            IDLE: begin
                pn_nxt    = '0;
                grant_nxt = 4'b0000;
                if (pick_vld) begin
                    idx_nxt   = pick;
                    n_nxt     = n_in[pick];
                    k_nxt     = k_in[pick];
                    grant_nxt = 4'b0001 << pick;
                    pn_nxt    = n_in[pick];
                    state_nxt = LOAD;
                end
            end
            // The generator is still counting against the old N here, so
            // Pulse is not looked at.
            LOAD: begin
                if (n_lat == '0 || k_lat == '0) begin
                    done_nxt  = grant_q;
                    err_nxt   = 1'b1;
                    pn_nxt    = '0;
                    grant_nxt = 4'b0000;
                    state_nxt = FIN;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.Pulse) begin
                    cnt_nxt = cnt + 1'b1;
                end
                // An abandoned request wins over a coincident final pulse.
                if (!bus.Req[idx]) begin
                    pn_nxt    = '0;
                    grant_nxt = 4'b0000;
                    state_nxt = FIN;
                end else if (bus.Pulse && cnt == k_lat - 1'b1) begin
                    done_nxt  = grant_q;
                    pn_nxt    = '0;
                    grant_nxt = 4'b0000;
                    state_nxt = FIN;
                end
            end
            FIN: begin
                ptr_nxt   = idx + 2'd1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            idx     <= 2'd0;
            n_lat   <= '0;
            k_lat   <= '0;
            cnt     <= '0;
            pn_q    <= '0;
            grant_q <= 4'b0000;
            done_q  <= 4'b0000;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            idx     <= idx_nxt;
            n_lat   <= n_nxt;
            k_lat   <= k_nxt;
            cnt     <= cnt_nxt;
            pn_q    <= pn_nxt;
            grant_q <= grant_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
            busy_q  <= busy_nxt;
        end
    end

    assign bus.PN    = pn_q;
    assign bus.Grant = grant_q;
    assign bus.Done  = done_q;
    assign bus.Err   = err_q;
    assign bus.Busy  = busy_q;
    assign bus.Tick  = (state == RUN && bus.Pulse) ? grant_q : 4'b0000;

endmodule

// File: tb/tb_pulse_sched_arbiter.sv
module tb_pulse_sched_arbiter;

    logic Clk;
    logic Reset;

    pulse_sched_arbiter_if #(.WIDTH(10), .KW(8)) bus ();

    pulse_sched_arbiter #(.WIDTH(10), .KW(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0] req;
        logic       pulse;
        logic [3:0] tick;   // expected before the edge
        logic [3:0] grant;  // expected after the edge
        logic [9:0] pn;
        logic [3:0] done;
        logic       err;
        logic       busy;
    } vec_t;

    vec_t  tbl[$];
    int    total = 0;
    int    bad   = 0;
    string cur   = "";

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s[%0d]: got %0h expected %0h", cur, nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] req, input logic pulse, input logic [3:0] tick,
                       input logic [3:0] grant, input logic [9:0] pn, input logic [3:0] done,
                       input logic err, input logic busy);
        vec_t v;
        v.req = req; v.pulse = pulse; v.tick = tick; v.grant = grant;
        v.pn = pn; v.done = done; v.err = err; v.busy = busy;
        tbl.push_back(v);
    endtask

    task automatic set_cfg(input logic [9:0] n0, n1, n2, n3, input logic [7:0] k0, k1, k2, k3);
        bus.N0 = n0; bus.N1 = n1; bus.N2 = n2; bus.N3 = n3;
        bus.K0 = k0; bus.K1 = k1; bus.K2 = k2; bus.K3 = k3;
    endtask

    task automatic check_zero(input int idx);
        chk("grant", idx, 32'(bus.Grant), 0);
        chk("pn",    idx, 32'(bus.PN),    0);
        chk("done",  idx, 32'(bus.Done),  0);
        chk("err",   idx, 32'(bus.Err),   0);
        chk("busy",  idx, 32'(bus.Busy),  0);
        chk("tick",  idx, 32'(bus.Tick),  0);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        bus.Req = 4'b0000;
        bus.Pulse = 1'b1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check_zero(-1);
        @(negedge Clk);
        Reset = 1'b0;
        bus.Pulse = 1'b0;
        tbl.delete();
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge Clk);
            bus.Req   = tbl[i].req;
            bus.Pulse = tbl[i].pulse;
            #1;
            chk("tick", i, 32'(bus.Tick), 32'(tbl[i].tick));
            @(posedge Clk);
            #1;
            chk("grant", i, 32'(bus.Grant), 32'(tbl[i].grant));
            chk("pn",    i, 32'(bus.PN),    32'(tbl[i].pn));
            chk("done",  i, 32'(bus.Done),  32'(tbl[i].done));
            chk("err",   i, 32'(bus.Err),   32'(tbl[i].err));
            chk("busy",  i, 32'(bus.Busy),  32'(tbl[i].busy));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        logic got_done;

        Reset = 1'b0;
        bus.Req = 4'b0000;
        bus.Pulse = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);

        // Single requester, N0=4, K0=3, pulses one period (4 cycles) apart
        cur = "single";
        set_cfg(4, 0, 0, 0, 3, 0, 0, 0);
        do_reset();
        add(1, 0, 0, 1, 4, 0, 0, 1);
        add(1, 1, 0, 1, 4, 0, 0, 1);
        add(1, 1, 1, 1, 4, 0, 0, 1);
        for (int r = 0; r < 3; r++) add(1, 0, 0, 1, 4, 0, 0, 1);
        add(1, 1, 1, 1, 4, 0, 0, 1);
        for (int r = 0; r < 3; r++) add(1, 0, 0, 1, 4, 0, 0, 1);
        add(1, 1, 1, 0, 0, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        run_table();

        // Round robin with all four requesting
        cur = "rr";
        set_cfg(2, 2, 2, 2, 1, 1, 1, 1);
        do_reset();
        for (int g = 0; g < 4; g++) begin
            add(4'hF, 0, 0, 4'(1 << g), 2, 0, 0, 1);
            add(4'hF, 0, 0, 4'(1 << g), 2, 0, 0, 1);
            add(4'hF, 1, 4'(1 << g), 0, 0, 4'(1 << g), 0, 1);
            add(4'hF, 0, 0, 0, 0, 0, 0, 0);
        end
        add(4'hF, 0, 0, 1, 2, 0, 0, 1);
        run_table();

        // Same N back-to-back: PN must pass through 0 between owners
        cur = "samen";
        set_cfg(5, 5, 0, 0, 2, 2, 0, 0);
        do_reset();
        add(3, 0, 0, 1, 5, 0, 0, 1);
        add(3, 0, 0, 1, 5, 0, 0, 1);
        add(3, 1, 1, 1, 5, 0, 0, 1);
        for (int r = 0; r < 4; r++) add(3, 0, 0, 1, 5, 0, 0, 1);
        add(3, 1, 1, 0, 0, 1, 0, 1);
        add(2, 0, 0, 0, 0, 0, 0, 0);
        add(2, 0, 0, 2, 5, 0, 0, 1);
        add(2, 0, 0, 2, 5, 0, 0, 1);
        add(2, 1, 2, 2, 5, 0, 0, 1);
        for (int r = 0; r < 4; r++) add(2, 0, 0, 2, 5, 0, 0, 1);
        add(2, 1, 2, 0, 0, 2, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        run_table();

        // Zero N on requester 2, then zero K on requester 1
        cur = "zero";
        set_cfg(0, 9, 0, 0, 0, 0, 7, 0);
        do_reset();
        add(4, 0, 0, 4, 0, 0, 0, 1);
        add(4, 1, 0, 0, 0, 4, 1, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(2, 0, 0, 2, 9, 0, 0, 1);
        add(2, 1, 0, 0, 0, 2, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        run_table();

        // Abort after 2nd tick (with a pulse in the abort cycle), then the
        // pending requester 1 aborts on its final pulse: no Done either time
        cur = "abort";
        set_cfg(10, 3, 0, 0, 5, 1, 0, 0);
        do_reset();
        add(1, 0, 0, 1, 10, 0, 0, 1);
        add(1, 0, 0, 1, 10, 0, 0, 1);
        add(1, 1, 1, 1, 10, 0, 0, 1);
        add(1, 0, 0, 1, 10, 0, 0, 1);
        add(1, 1, 1, 1, 10, 0, 0, 1);
        add(3, 0, 0, 1, 10, 0, 0, 1);
        add(2, 1, 1, 0, 0, 0, 0, 1);
        add(2, 0, 0, 0, 0, 0, 0, 0);
        add(2, 0, 0, 2, 3, 0, 0, 1);
        add(2, 0, 0, 2, 3, 0, 0, 1);
        add(0, 1, 2, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        run_table();

        // Reset asserted mid-RUN, then a fresh grant runs to completion
        cur = "rstrun";
        set_cfg(8, 0, 0, 0, 4, 0, 0, 0);
        do_reset();
        add(1, 0, 0, 1, 8, 0, 0, 1);
        add(1, 0, 0, 1, 8, 0, 0, 1);
        add(1, 1, 1, 1, 8, 0, 0, 1);
        run_table();
        @(negedge Clk);
        bus.Pulse = 1'b1;
        #1;
        chk("tick_pre", 0, 32'(bus.Tick), 1);
        Reset = 1'b1;
        #1;
        check_zero(100);
        @(negedge Clk);
        Reset = 1'b0;
        bus.Pulse = 1'b0;
        @(posedge Clk);
        #1;
        chk("regrant", 0, 32'(bus.Grant), 1);
        chk("repn",    0, 32'(bus.PN),    8);
        ticks = 0;
        got_done = 1'b0;
        for (int c = 0; c < 60 && !got_done; c++) begin
            @(negedge Clk);
            bus.Pulse = c[0];
            #1;
            if (bus.Tick[0]) ticks++;
            @(posedge Clk);
            #1;
            if (bus.Done[0]) got_done = 1'b1;
        end
        chk("done_seen", 0, 32'(got_done), 1);
        chk("ticks",     0, 32'(ticks),    4);
        chk("err_end",   0, 32'(bus.Err),  0);
        @(negedge Clk);
        bus.Req = 4'b0000;
        bus.Pulse = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_sched_arbiter.md
Name: pulse_sched_arbiter

Overview:
- Round-robin scheduler that shares one programmable pulse-at-N generator among 4 requesters (game timers, e.g. tile-slide animation, key repeat, blink).
- The winning requester's terminal count is driven onto the generator's N input.
- Returned pulses are counted and routed back to the winner. Ownership is released after the requested number of pulses.

Parameters:
WIDTH, 10, width of the terminal count N (N <= 1000)
KW, 8, width of the requested pulse count K

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
Req  input  4  request bits; Req[i] is held high until Done[i] or until the requester abandons
N0..N3  input  WIDTH each  terminal count for requester i; sampled at grant
K0..K3  input  KW each  number of pulses wanted by requester i; sampled at grant
Pulse  input  1  pulse output returned from the shared generator
PN  output  WIDTH  N value driven to the shared generator
Grant  output  4  one-hot owner of the generator, or all zero
Tick  output  4  Tick[g] = Pulse while in RUN and owned by g; all other bits 0
Done  output  4  one-cycle completion strobe to the owner
Err  output  1  one-cycle strobe, coincident with Done, when the latched N or K was 0
Busy  output  1  high in every state except IDLE

Behaviour:
- Reset values (async): state=IDLE, PN=0, Grant=0, Tick=0, Done=0, Err=0, Busy=0, RR pointer=0, pulse counter=0, latched N/K/index=0.
- All outputs except Tick are registered. Tick is combinational: Pulse gated by state==RUN and the grant index.
- FSM states: IDLE, LOAD, RUN, FIN.
- IDLE:
  - PN=0.
  - If any Req bit is set, pick the first set bit searching from ptr, ptr+1, ... mod 4.
  - Latch the index, Ni and Ki; set Grant one-hot; go to LOAD.
- LOAD (exactly 1 cycle):
  - PN = latched N.
  - Pulse is ignored: the generator's count is stale until it sees the N change.
  - If N==0 or K==0, go to FIN with Err pending. Otherwise clear the pulse counter and go to RUN.
- RUN:
  - Each cycle Pulse=1, increment the counter.
  - When Pulse=1 and counter==K-1, go to FIN (completion).
  - If Req[g] drops, go to FIN with abort. Abort has priority over a simultaneous final Pulse: no Done is given, but Tick still shows that Pulse.
- FIN (1 cycle):
  - PN=0, Grant=0.
  - Done[g]=1 on completion or on the Err path; Err=1 only on the Err path. No Done on abort.
  - ptr = g+1 mod 4; go to IDLE.
- Latency:
  - Req rising in IDLE at edge t gives Grant/PN at t+1.
  - RUN begins at t+2.
  - Done appears 1 cycle after the cycle holding the K-th Pulse.
  - Minimum idle gap between grants: FIN and IDLE each last 1 cycle.
- PN returns to 0 between every grant. This forces the generator to see an N change and resynchronise, even when consecutive owners use the same N.
- Ni/Ki changes after grant are ignored until the next grant.
- Pulse outside RUN never reaches Tick and never advances the counter.
- Requests arriving while Busy wait. Req bits of non-owners are never dropped internally.
- Reset mid-RUN returns to IDLE immediately: PN=0, no Done.

Test Plan:
1. Single requester: Req=0001, N0=4, K0=3. Grant=0001 one cycle after Req. Tick[0] fires 3 times, one generator period apart. Done[0] one cycle after the 3rd Tick. Err=0. PN=0 in FIN.
2. Round robin: Req=1111 held, all N=2, K=1. Grant order is 0001, 0010, 0100, 1000, 0001. Each Done is followed by a 1-cycle IDLE.
3. Same-N back-to-back: req0 then req1, both N=5, K=2. PN goes 5 → 0 → 5 across the handover. The second owner's first Tick appears no earlier than the first owner's did.
4. Zero config: N2=0, K2=7. Sequence LOAD → FIN with Done[2]=1 and Err=1, no Tick. Separately K1=0, N1=9 gives the same result.
5. Abort: Req=0001, N0=10, K0=5; drop Req[0] after the 2nd Tick. FIN with Done=0 and ptr=1. A pending Req[1] is granted next.
6. Reset mid-RUN (N=8, K=4, after 1 Tick): all outputs are 0 on the cycle Reset asserts. After release with Req still high, a fresh grant completes with 4 Ticks.
